// File: rtl/rgb_pwm_gen.sv
// rgb_pwm_gen: three-channel PWM driver for the RGB LED pins.
// Duty values are double-buffered and only change at a PWM period boundary.
// Optional fade mode: define RGB_PWM_FADE_EN to ramp each channel toward its
// new target by FADE_STEP per period instead of jumping directly.
module rgb_pwm_gen #(
    parameter int PRESCALE       = 4,
    parameter bit LED_ACTIVE_LOW = 1'b0,
    parameter int FADE_STEP      = 4
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] R_time_in,
    input  logic [7:0] G_time_in,
    input  logic [7:0] B_time_in,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       period_start
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);
    localparam logic [7:0] PWM_MAX = 8'd254;

    // Elaboration-time parameter range checks.
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("rgb_pwm_gen: PRESCALE must be in 1..256");
    end
    if (FADE_STEP < 1 || FADE_STEP > 255) begin : g_bad_fade_step
        $error("rgb_pwm_gen: FADE_STEP must be in 1..255");
    end

    logic [0:0] state;
    logic [7:0] pre_cnt;
    logic [7:0] pwm_cnt;
    logic [7:0] duty_active_r;
    logic [7:0] duty_active_g;
    logic [7:0] duty_active_b;
    logic       on_r;
    logic       on_g;
    logic       on_b;
    logic       tick;
    logic       boundary;

`ifdef RGB_PWM_FADE_EN
    localparam logic [7:0] STEP = 8'(FADE_STEP);

    // Move one step toward the target; snap when within one step, so the
    // add/subtract below can never leave the 0..255 range.
    function automatic logic [7:0] next_duty(input logic [7:0] cur,
                                             input logic [7:0] tgt);
        logic [7:0] diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            next_duty = (diff <= STEP) ? tgt : cur + STEP;
        end else begin
            diff = cur - tgt;
            next_duty = (diff <= STEP) ? tgt : cur - STEP;
        end
    endfunction
`else
    function automatic logic [7:0] next_duty(input logic [7:0] cur,
                                             input logic [7:0] tgt);
        logic [7:0] unused_cur;
        unused_cur = cur;
        next_duty  = tgt | (unused_cur & 8'h00);
    endfunction
`endif

    // Prescaler tick and end-of-period detection.
    always_comb begin
        tick     = (pre_cnt == PRE_MAX);
        boundary = (state == RUN) && tick && (pwm_cnt == PWM_MAX);
    end

    // State machine, counters, double-buffered duty registers and period marker.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pre_cnt       <= '0;
            pwm_cnt       <= '0;
            duty_active_r <= '0;
            duty_active_g <= '0;
            duty_active_b <= '0;
            period_start  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pre_cnt       <= '0;
                    pwm_cnt       <= '0;
                    duty_active_r <= R_time_in;
                    duty_active_g <= G_time_in;
                    duty_active_b <= B_time_in;
                    period_start  <= en;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state        <= IDLE;
                        pre_cnt      <= '0;
                        pwm_cnt      <= '0;
                        period_start <= 1'b0;
                    end else begin
                        period_start <= boundary;
                        pre_cnt      <= tick ? '0 : pre_cnt + 8'd1;
                        if (tick) begin
                            pwm_cnt <= (pwm_cnt == PWM_MAX) ? '0 : pwm_cnt + 8'd1;
                        end
                        if (boundary) begin
                            duty_active_r <= next_duty(duty_active_r, R_time_in);
                            duty_active_g <= next_duty(duty_active_g, G_time_in);
                            duty_active_b <= next_duty(duty_active_b, B_time_in);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered duty compare; channels are only ever on while running.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            on_r <= 1'b0;
            on_g <= 1'b0;
            on_b <= 1'b0;
        end else begin
            on_r <= (state == RUN) && (pwm_cnt < duty_active_r);
            on_g <= (state == RUN) && (pwm_cnt < duty_active_g);
            on_b <= (state == RUN) && (pwm_cnt < duty_active_b);
        end
    end

    assign led_r = on_r ^ LED_ACTIVE_LOW;
    assign led_g = on_g ^ LED_ACTIVE_LOW;
    assign led_b = on_b ^ LED_ACTIVE_LOW;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Testbench for rgb_pwm_gen: two instances (PRESCALE=1 active-high and
// PRESCALE=3 active-low) share stimulus and are compared every cycle against
// a time-since-start reference model.
module tb_rgb_pwm_gen;

    logic       clk_div = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] r_t;
    logic [7:0] g_t;
    logic [7:0] b_t;

    logic a_r, a_g, a_b, a_ps;
    logic b_r, b_g, b_b, b_ps;

    int checks = 0;
    int fails  = 0;

    always #5 clk_div = ~clk_div;

    rgb_pwm_gen #(.PRESCALE(1), .LED_ACTIVE_LOW(1'b0), .FADE_STEP(4)) dut_a (
        .clk_div(clk_div), .rst(rst), .en(en),
        .R_time_in(r_t), .G_time_in(g_t), .B_time_in(b_t),
        .led_r(a_r), .led_g(a_g), .led_b(a_b), .period_start(a_ps)
    );

    rgb_pwm_gen #(.PRESCALE(3), .LED_ACTIVE_LOW(1'b1), .FADE_STEP(4)) dut_b (
        .clk_div(clk_div), .rst(rst), .en(en),
        .R_time_in(r_t), .G_time_in(g_t), .B_time_in(b_t),
        .led_r(b_r), .led_g(b_g), .led_b(b_b), .period_start(b_ps)
    );

    // Reference model: per instance, whether running, cycles since the first
    // RUN cycle, active duties, the compare result shown on the LEDs and the
    // period marker.
    int ps_of[2];
    bit alow_of[2];
    bit m_run[2];
    int m_k[2];
    int m_duty[2][3];
    bit m_on[2][3];
    bit m_ps[2];

    function automatic int fade(input int a, input int t);
`ifdef RGB_PWM_FADE_EN
        if ((t - a) <= 4 && (a - t) <= 4) return t;
        else if (t > a) return a + 4;
        else return a - 4;
`else
        return t + 0 * a;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0;
            m_k[i]   = 0;
            m_ps[i]  = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_duty[i][c] = 0;
                m_on[i][c]   = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        int tgt[3];
        int per;
        int pwm;
        bit nxt[3];
        tgt[0] = int'(r_t);
        tgt[1] = int'(g_t);
        tgt[2] = int'(b_t);
        for (int i = 0; i < 2; i++) begin
            per = 255 * ps_of[i];
            pwm = (m_k[i] % per) / ps_of[i];
            for (int c = 0; c < 3; c++) nxt[c] = m_run[i] && (pwm < m_duty[i][c]);
            if (!m_run[i]) begin
                for (int c = 0; c < 3; c++) m_duty[i][c] = tgt[c];
                m_ps[i] = en;
                if (en) begin
                    m_run[i] = 1'b1;
                    m_k[i]   = 0;
                end
            end else if (!en) begin
                m_run[i] = 1'b0;
                m_ps[i]  = 1'b0;
            end else begin
                m_k[i] = m_k[i] + 1;
                if (m_k[i] % per == 0) begin
                    for (int c = 0; c < 3; c++) m_duty[i][c] = fade(m_duty[i][c], tgt[c]);
                    m_ps[i] = 1'b1;
                end else begin
                    m_ps[i] = 1'b0;
                end
            end
            for (int c = 0; c < 3; c++) m_on[i][c] = nxt[c];
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_vec(input int i);
        return {m_on[i][0] ^ alow_of[i], m_on[i][1] ^ alow_of[i],
                m_on[i][2] ^ alow_of[i], m_ps[i]};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_a"}, {a_r, a_g, a_b, a_ps}, exp_vec(0));
        chk({tag, "_b"}, {b_r, b_g, b_b, b_ps}, exp_vec(1));
    endtask

    task automatic step(input string tag);
        @(posedge clk_div);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        step(tag);
        rst = 1'b0;
    endtask

    initial begin
        int cnt_b;
        int cnt_g;
        int cnt_ps;
        ps_of[0]   = 1;
        ps_of[1]   = 3;
        alow_of[0] = 1'b0;
        alow_of[1] = 1'b1;
        rst = 1'b1;
        en  = 1'b0;
        r_t = 8'd0;
        g_t = 8'd0;
        b_t = 8'd0;
        model_reset();

        // Reset state, held across a few edges.
        #2;
        check_outputs("reset");
        for (int n = 0; n < 3; n++) step("reset_hold");
        rst = 1'b0;

        // Idle with en low: LEDs stay off whatever the inputs do.
        for (int n = 0; n < 1000; n++) begin
            step("idle");
            if (n % 97 == 0) begin
                r_t = 8'($urandom);
                g_t = 8'($urandom);
                b_t = 8'($urandom);
            end
        end

        // Duty extremes: 0, 255 and 128, two full periods on the PRESCALE=1 unit.
        r_t = 8'd0;
        g_t = 8'd255;
        b_t = 8'd128;
        en  = 1'b1;
        cnt_b  = 0;
        cnt_g  = 0;
        cnt_ps = 0;
        for (int n = 0; n < 510; n++) begin
            step("extremes");
            cnt_b  += int'(a_b);
            cnt_g  += int'(a_g);
            cnt_ps += int'(a_ps);
        end
        chk_int("extremes_b_high", cnt_b, 256);
        chk_int("extremes_g_high", cnt_g, 509);
        chk_int("extremes_ps_count", cnt_ps, 2);

        // Mid-period target change on the slower unit, then an enable drop.
        r_t = 8'd64;
        for (int n = 0; n < 300; n++) step("dbuf_pre");
        r_t = 8'd200;
        for (int n = 0; n < 1200; n++) step("dbuf_post");
        en = 1'b0;
        for (int n = 0; n < 5; n++) step("en_drop");
        en = 1'b1;
        for (int n = 0; n < 40; n++) step("en_raise");

        // Asynchronous reset while all channels are high.
        r_t = 8'd200;
        g_t = 8'd180;
        b_t = 8'd150;
        for (int n = 0; n < 900; n++) step("pre_reset");
        async_reset("async_rst");
        for (int n = 0; n < 20; n++) step("post_reset");

        // Fade / direct-load ramp 0 -> 10 on the red channel.
        r_t = 8'd0;
        for (int n = 0; n < 800; n++) step("ramp_zero");
        r_t = 8'd10;
        for (int n = 0; n < 3200; n++) step("ramp");

        // Randomised run: target changes, enable toggles, occasional resets.
        for (int n = 0; n < 6000; n++) begin
            step("random");
            if ($urandom_range(0, 39) == 0) begin
                r_t = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
                g_t = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                b_t = 8'($urandom);
            end
            if (en && $urandom_range(0, 599) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
            if ($urandom_range(0, 1499) == 0) async_reset("random_rst");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_gen.md
# rgb_pwm_gen

Downstream stage of the colour-sequence decoder: takes the three 8-bit duty values (R/G/B time) and turns them into three PWM drive signals for the RGB LED pins. Duty values are double-buffered and only take effect at a PWM period boundary, so a colour change never produces a truncated or glitched pulse. An optional fade mode ramps each channel toward its new target over successive periods.

## Interface
- PRESCALE, 4: clk_div cycles per PWM tick; legal range 1..256.
- LED_ACTIVE_LOW, 0: 1 inverts all three LED outputs (on = 0).
- FADE_STEP, 4: duty increment per period in fade mode; legal range 1..255; ignored unless RGB_PWM_FADE_EN is defined.
- clk_div  input  1  PWM clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  run enable; 0 = idle, LEDs off.
- R_time_in  input  8  red target duty, 0 = off, 255 = fully on.
- G_time_in  input  8  green target duty.
- B_time_in  input  8  blue target duty.
- led_r  output  1  red PWM drive.
- led_g  output  1  green PWM drive.
- led_b  output  1  blue PWM drive.
- period_start  output  1  one-cycle pulse marking the first cycle of each PWM period.

## Operation
- State machine with two states, IDLE and RUN; reset state is IDLE.
- IDLE
  - pre_cnt = 0 and pwm_cnt = 0.
  - LEDs at the off level.
  - duty_active_x loads from x_time_in every cycle.
  - en=1 moves the block to RUN on the next edge. On that same edge period_start <= 1.
- RUN
  - pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt == PRESCALE-1).
  - On tick, pwm_cnt counts 0..254 and wraps, so one period is 255 ticks = 255*PRESCALE clk_div cycles.
  - Boundary = tick while pwm_cnt == 254. On that edge:
    - pwm_cnt <= 0.
    - duty_active_x updates from x_time_in sampled on the same edge.
    - period_start <= 1.
  - At all other times duty_active_x holds. Input changes mid-period are ignored until the next boundary.
  - en=0 moves the block to IDLE on the next edge, from any counter value; no period completion.
- Compare: channel on iff state == RUN and pwm_cnt < duty_active_x.
  - Duty 0 never turns on; duty 255 is on for the whole period (pwm_cnt max 254).
  - Result is registered, then XORed with LED_ACTIVE_LOW.
- Widths: pre_cnt is 8 bits, wide enough for values 0..255. pwm_cnt is 8 bits. Comparisons are unsigned 8-bit.
- en and rst may arrive at any time. An en toggle inside a single cycle is irrelevant; en is sampled on clk_div.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - pre_cnt = 0, pwm_cnt = 0, duty_active_x = 0.
  - period_start = 0.
  - led_x = LED_ACTIVE_LOW (off level).
- LED latency: led_x(t+1) reflects pwm_cnt(t) and duty_active_x(t); one clk_div cycle of register latency.
- First RUN period: period_start is high in the first RUN cycle. led_x first reflects pwm_cnt = 0 one cycle later.
- Subsequent periods: period_start is high exactly one cycle, on the cycle in which pwm_cnt = 0 and pre_cnt = 0. It is never high in two consecutive cycles unless PRESCALE*255 = 1, which is not legal.
- Input change to LED effect: a new duty takes effect at the first boundary after it is sampled. Worst case is one full period plus one cycle.
- RUN→IDLE: LEDs reach the off level on the edge after the state becomes IDLE.
- Reset mid-run: all outputs go to their reset values immediately. After rst is released, the next RUN period starts from pwm_cnt = 0.

## Configuration
- RGB_PWM_FADE_EN defined:
  - At each boundary, duty_active_x moves toward the sampled target by FADE_STEP.
  - If |target − active| ≤ FADE_STEP, active = target.
  - There is no overflow or underflow; the result is clamped to 0..255.
  - In IDLE the load is still direct, with no fade.
- RGB_PWM_FADE_EN undefined: duty_active_x = target at each boundary. No fade logic is synthesized and FADE_STEP is unused.

## Test plan
- Reset and idle: assert rst with en=0 → led_r/g/b = 0 and period_start = 0. Release rst with en held low → outputs stay 0 for 1000 cycles. Repeat with LED_ACTIVE_LOW=1 → all LEDs stay 1.
- Duty extremes: PRESCALE=1; R=0, G=255, B=128; raise en.
  - period_start pulses every 255 cycles.
  - led_r stays 0.
  - led_g is 1 in all 255 cycles of each period.
  - led_b is high for exactly 128 consecutive cycles per period, starting 1 cycle after period_start.
- Double buffering: PRESCALE=2, R=64. Change R to 200 while pwm_cnt = 100 → the current period shows 64 ticks (128 cycles) high; the next period shows 200 ticks (400 cycles) high.
- Enable drop: drop en at pwm_cnt = 50 → LEDs off within 2 cycles. Re-raise en → period_start pulses in the first RUN cycle and counting restarts from 0.
- Async reset mid-run: assert rst between clock edges during a high pulse → led_x drops to 0 before the next clk_div edge; duty_active returns to 0.
- Fade: RGB_PWM_FADE_EN defined, FADE_STEP=4, R steps 0→10 while running → per-period red high counts are 4, 8, 10, 10. Without the macro → 10 from the first boundary.
